alu_muldiv_seq: RTL



---
 rtl/alu_muldiv_seq_pkg.sv | 35 +++
 rtl/alu_muldiv_seq_if.sv | 37 +++
 rtl/alu_muldiv_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU opcodes, FSM
// state encoding and operation selectors.
package alu_muldiv_seq_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_PASSA = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd12;
  localparam logic [ALU_OP_W-1:0] ALU_NAND  = 4'd13;
  localparam logic [ALU_OP_W-1:0] ALU_XNOR  = 4'd14;
  localparam logic [ALU_OP_W-1:0] ALU_NOTA  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_DONE = 3'd2,
    S_PRE  = 3'd3,
    S_POST = 3'd4
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Start/result handshake bundle between a requester and the multiply/divide
// sequencer. op_signed exists only when MULDIV_SIGNED_EN is defined.
interface alu_muldiv_seq_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  start_valid;
  logic                  start_ready;
  logic                  op;
  logic [DATA_WIDTH-1:0] opa;
  logic [DATA_WIDTH-1:0] opb;
`ifdef MULDIV_SIGNED_EN
  logic                  op_signed;
`endif
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_hi;
  logic [DATA_WIDTH-1:0] res_lo;
  logic                  div_by_zero;

  modport master (
`ifdef MULDIV_SIGNED_EN
    output op_signed,
`endif
    output start_valid, op, opa, opb, res_ready,
    input  start_ready, res_valid, res_hi, res_lo, div_by_zero
  );

  modport slave (
`ifdef MULDIV_SIGNED_EN
    input  op_signed,
`endif
    input  start_valid, op, opa, opb, res_ready,
    output start_ready, res_valid, res_hi, res_lo, div_by_zero
  );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Multicycle shift-add multiply / restoring divide sequencer driving an external
// combinational ALU. Define MULDIV_SIGNED_EN for signed operation (PRE/POST states).
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OP_SIZE    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_muldiv_seq_if.slave       bus,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_SIZE-1:0]    alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_cout
);

  localparam int            W         = DATA_WIDTH;
  localparam int            CW        = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  state_t r_state, w_state_nxt;

  // r_hi is the product high half or the remainder; r_lo is the product low
  // half or the quotient; r_b is the multiplicand or the divisor.
  logic          r_op;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res_hi;
  logic [W-1:0]  r_res_lo;
  logic          r_dbz;

  logic          w_dbz_req;
  logic          w_last;
  logic [W:0]    w_t;
  logic          w_ge;
  logic          w_c;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_hi_nxt;
  logic [W-1:0]  w_lo_nxt;

`ifdef MULDIV_SIGNED_EN
  logic          r_sa;
  logic          r_sb;
  logic          w_lo_neg;
  logic          w_b_neg;
  logic [2*W-1:0] w_prod_neg;

  assign w_lo_neg   = (r_op == OP_DIV) ? r_sa : r_sb;
  assign w_b_neg    = (r_op == OP_DIV) ? r_sb : r_sa;
  assign w_prod_neg = -{r_res_hi, r_res_lo};
`endif

  assign w_dbz_req = (bus.op == OP_DIV) && (bus.opb == '0);
  assign w_last    = (r_count == '0);

  assign bus.res_hi      = r_res_hi;
  assign bus.res_lo      = r_res_lo;
  assign bus.div_by_zero = r_dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    w_state_nxt     = r_state;
    bus.start_ready = 1'b0;
    bus.res_valid   = 1'b0;
    busy            = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.start_ready = 1'b1;
        busy            = 1'b0;
        if (bus.start_valid) begin
`ifdef MULDIV_SIGNED_EN
          w_state_nxt = w_dbz_req ? S_POST : S_PRE;
`else
          w_state_nxt = w_dbz_req ? S_DONE : S_RUN;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_PRE:  w_state_nxt = S_RUN;
      S_POST: w_state_nxt = S_DONE;
      S_RUN:  if (w_last) w_state_nxt = S_POST;
`else
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
`endif
      S_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration of either algorithm. The stored remainder needs only W bits:
  // whenever t[W] is set, ge is forced and the remainder becomes alu_out.
  always_comb begin
    w_t   = {r_hi, r_lo[W-1]};
    w_ge  = w_t[W] | (w_t[W-1:0] >= r_b);
    w_c   = r_lo[0] & alu_cout;
    w_sum = r_lo[0] ? alu_out : r_hi;
    if (r_op == OP_DIV) begin
      w_hi_nxt = w_ge ? alu_out : w_t[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], w_ge};
    end else begin
      w_hi_nxt = {w_c, w_sum[W-1:1]};
      w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
    end
  end

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = OP_SIZE'(ALU_ADD);
    if (r_state == S_RUN) begin
      alu_b = r_b;
      if (r_op == OP_DIV) begin
        alu_a    = w_t[W-1:0];
        alu_ctrl = OP_SIZE'(ALU_SUB);
      end else begin
        alu_a = r_hi;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_MUL;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dbz    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.start_valid) begin
          r_op    <= bus.op;
          r_count <= LAST_STEP;
          r_hi    <= '0;
          r_lo    <= (bus.op == OP_DIV) ? bus.opa : bus.opb;
          r_b     <= (bus.op == OP_DIV) ? bus.opb : bus.opa;
`ifdef MULDIV_SIGNED_EN
          r_sa    <= bus.op_signed & bus.opa[W-1];
          r_sb    <= bus.op_signed & bus.opb[W-1];
`endif
          if (w_dbz_req) begin
            r_res_hi <= bus.opa;
            r_res_lo <= '1;
            r_dbz    <= 1'b1;
          end
        end
        S_RUN: begin
          r_hi    <= w_hi_nxt;
          r_lo    <= w_lo_nxt;
          r_count <= r_count - 1'b1;
          if (w_last) begin
            r_res_hi <= w_hi_nxt;
            r_res_lo <= w_lo_nxt;
            r_dbz    <= 1'b0;
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_PRE: begin
          if (w_lo_neg) r_lo <= -r_lo;
          if (w_b_neg)  r_b  <= -r_b;
        end
        // Quotient truncates toward zero, so the remainder follows the dividend.
        S_POST: if (!r_dbz) begin
          if (r_op == OP_MUL) begin
            if (r_sa ^ r_sb) {r_res_hi, r_res_lo} <= w_prod_neg;
          end else begin
            if (r_sa ^ r_sb) r_res_lo <= -r_res_lo;
            if (r_sa)        r_res_hi <= -r_res_hi;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
